// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 multi-channel convolution block.
// Holds the datapath widths, the frame-sequencer dimensions and the
// sequencer state encoding.
package conv_pkg;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 20;
  localparam int IN_CH   = 4;
  localparam int OUT_CH  = 8;

  localparam int COORD_W = 10;
  localparam int CREDITS = 4;
  localparam int INFL_W  = 6;
  localparam int MIN_DIM = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WLOAD = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/conv_sched_if.sv
// Window/datapath handshake bundle between conv_sched and its neighbours.
//   wload_req/wload_ack : weight-bank refresh handshake
//   win_rdy             : fetcher has the window at win_row/win_col
//   win_valid/row/col   : window issue to the datapath valid_in
//   res_valid           : datapath valid_out, one bit per output channel
//   credit_ret          : output buffer consumed one result
// master = scheduler side, slave = fetcher/datapath/output-buffer side.
interface conv_sched_if #(
  parameter int COORD_W = conv_pkg::COORD_W,
  parameter int OUT_CH  = conv_pkg::OUT_CH
);
  logic               wload_req;
  logic               wload_ack;
  logic               win_rdy;
  logic               win_valid;
  logic [COORD_W-1:0] win_row;
  logic [COORD_W-1:0] win_col;
  logic [OUT_CH-1:0]  res_valid;
  logic               credit_ret;

  modport master (
    output wload_req, win_valid, win_row, win_col,
    input  wload_ack, win_rdy, res_valid, credit_ret
  );

  modport slave (
    input  wload_req, win_valid, win_row, win_col,
    output wload_ack, win_rdy, res_valid, credit_ret
  );
endinterface

// File: rtl/conv_sched_credit.sv
// Up/down counter saturating at 0 and MAX. inc and dec together leave the
// count unchanged; a step that would cross a bound is dropped.
//   clk, rstn : clock, async active-low reset (count returns to RST_VAL)
//   inc, dec  : count up / count down requests
//   cnt       : current count
module conv_sched_credit #(
  parameter int WIDTH   = 6,
  parameter int MAX     = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= RST_V;
    end else if (inc && !dec && cnt != MAX_V) begin
      cnt <= cnt + WIDTH'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end
endmodule

// File: rtl/conv_sched.sv
// Frame sequencer for the 3x3 convolution datapath: weight-bank load, then a
// raster scan of every valid 3x3 window, flow-controlled by output-buffer
// credits; done is signalled once every issued result has come back.
//   clk, rstn     : clock, async active-low reset
//   start         : frame start pulse; cfg_w/cfg_h latched when accepted
//   busy/done     : frame in progress / one-cycle end-of-frame pulse
//   cfg_err       : one-cycle pulse for a start with a dimension below 3
//   sync_err      : sticky, res_valid lanes disagreed
//   bus (master)  : weight-load, window-issue, result and credit handshakes
//
// state | meaning
// IDLE  | waiting for start
// WLOAD | weight-bank refresh requested, waiting for wload_ack
// RUN   | issuing windows in raster order
// DRAIN | all windows issued, waiting for in-flight results
// DONE  | one-cycle done pulse
module conv_sched #(
  parameter int COORD_W = conv_pkg::COORD_W,
  parameter int OUT_CH  = conv_pkg::OUT_CH,
  parameter int CREDITS = conv_pkg::CREDITS,
  parameter int INFL_W  = conv_pkg::INFL_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [COORD_W-1:0] cfg_w,
  input  logic [COORD_W-1:0] cfg_h,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               sync_err,
  conv_sched_if.master       bus
);
  import conv_pkg::*;

  sched_state_t       state_q, state_d;
  logic [COORD_W-1:0] w_lim_q, w_lim_d, h_lim_q, h_lim_d;
  logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
  logic [COORD_W-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
  logic               win_valid_q, win_valid_d;
  logic               busy_d, done_d, cfg_err_d, wload_req_q, wload_req_d, sync_err_d;
  logic [INFL_W-1:0]  credits, infl;
  logic [OUT_CH-1:0]  res;
  logic               issue, cfg_ok, res_split;

  assign res       = bus.res_valid;
  assign res_split = (res != '0) && (res != {OUT_CH{1'b1}});
  assign issue     = (state_q == S_RUN) && bus.win_rdy && (credits != '0);
  assign cfg_ok    = (cfg_w >= COORD_W'(MIN_DIM)) && (cfg_h >= COORD_W'(MIN_DIM));

  conv_sched_credit #(.WIDTH(INFL_W), .MAX(CREDITS), .RST_VAL(CREDITS)) u_credit (
    .clk(clk), .rstn(rstn), .inc(bus.credit_ret), .dec(issue), .cnt(credits)
  );

  conv_sched_credit #(.WIDTH(INFL_W), .MAX((1 << INFL_W) - 1), .RST_VAL(0)) u_infl (
    .clk(clk), .rstn(rstn), .inc(issue), .dec(res[0]), .cnt(infl)
  );

  always_comb begin
    state_d     = state_q;
    w_lim_d     = w_lim_q;
    h_lim_d     = h_lim_q;
    row_d       = row_q;
    col_d       = col_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_valid_d = 1'b0;
    cfg_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            // limits are the last valid top-left coordinate
            w_lim_d = cfg_w - COORD_W'(MIN_DIM);
            h_lim_d = cfg_h - COORD_W'(MIN_DIM);
            state_d = S_WLOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_WLOAD: begin
        if (bus.wload_ack) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          win_valid_d = 1'b1;
          win_row_d   = row_q;
          win_col_d   = col_q;
          if (col_q == w_lim_q) begin
            col_d = '0;
            row_d = row_q + COORD_W'(1);
            if (row_q == h_lim_q) state_d = S_DRAIN;
          end else begin
            col_d = col_q + COORD_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (infl == '0 && res == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d      = (state_d == S_WLOAD) || (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d      = (state_d == S_DONE);
    wload_req_d = (state_d == S_WLOAD);
    sync_err_d  = sync_err | res_split;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      w_lim_q     <= '0;
      h_lim_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_valid_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      wload_req_q <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_lim_q     <= w_lim_d;
      h_lim_q     <= h_lim_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_valid_q <= win_valid_d;
      busy        <= busy_d;
      done        <= done_d;
      cfg_err     <= cfg_err_d;
      wload_req_q <= wload_req_d;
      sync_err    <= sync_err_d;
    end
  end

  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign bus.wload_req = wload_req_q;
endmodule

// File: tb/tb_conv_sched.sv
module tb_conv_sched;
  import conv_pkg::*;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               start = 1'b0;
  logic [COORD_W-1:0] cfg_w = '0;
  logic [COORD_W-1:0] cfg_h = '0;
  logic               busy, done, cfg_err, sync_err;

  conv_sched_if bus ();

  conv_sched dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .busy(busy), .done(done), .cfg_err(cfg_err), .sync_err(sync_err), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // datapath/output-buffer model: latency 4, credit returned one cycle after result
  logic       dp_en = 1'b0;
  logic [3:0] pipe  = '0;
  logic [7:0] m_res = '0;
  logic [7:0] t_res = '0;
  logic       m_cr  = 1'b0;
  logic       t_cr  = 1'b0;

  assign bus.res_valid  = dp_en ? m_res : t_res;
  assign bus.credit_ret = dp_en ? m_cr : t_cr;

  always @(posedge clk) begin
    #1;
    m_cr  = m_res[0];
    pipe  = {pipe[2:0], bus.win_valid};
    m_res = pipe[3] ? 8'hFF : 8'h00;
  end

  // monitor
  logic [19:0] issq[$];
  int          res_cnt = 0;
  int          done_cnt = 0;
  int          rdy_bad = 0;
  int          hold_bad = 0;
  logic        rdy_at_edge = 1'b0;
  logic        hold_en = 1'b0;
  logic [9:0]  last_r = '0;
  logic [9:0]  last_c = '0;

  always @(posedge clk) rdy_at_edge = bus.win_rdy;

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.win_valid) begin
        issq.push_back({bus.win_row, bus.win_col});
        if (!rdy_at_edge) rdy_bad++;
      end else if (hold_en && (bus.win_row != last_r || bus.win_col != last_c)) begin
        hold_bad++;
      end
      if (bus.res_valid[0]) res_cnt++;
      if (done) done_cnt++;
    end
    last_r = bus.win_row;
    last_c = bus.win_col;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic start_frame(input int w, input int h);
    cfg_w = COORD_W'(w);
    cfg_h = COORD_W'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic ack_wload(input string nm);
    int n = 0;
    while (!bus.wload_req && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (bus.wload_req !== 1'b1) begin
      bad++;
      $display("FAIL %s_wload_req: got %b want 1", nm, bus.wload_req);
    end
    bus.wload_ack = 1'b1;
    tick();
    bus.wload_ack = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string nm);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      tick();
      n++;
    end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL %s_done_timeout: got no done in %0d cycles, want done pulse", nm, limit);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    logic [27:0] v;
    repeat (2) tick();
    v = {busy, done, cfg_err, sync_err, bus.wload_req, bus.win_valid, bus.win_row, bus.win_col};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", v);
    end
    rstn = 1'b1;
    repeat (2) tick();
    v = {busy, done, cfg_err, sync_err, bus.wload_req, bus.win_valid, bus.win_row, bus.win_col};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL idle_outputs: got %h want 0", v);
    end
  endtask

  task automatic test_basic();
    int r0, d0, k;
    dp_en = 1'b1;
    bus.win_rdy = 1'b1;
    issq.delete();
    r0 = res_cnt;
    d0 = done_cnt;
    start_frame(5, 5);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    ack_wload("basic");
    // start while busy must be ignored, even with a bad config
    cfg_w = 10'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL basic_start_busy: got cfg_err=%b want 0", cfg_err);
    end
    wait_done(300, "basic");
    total++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL basic_done_busy: got busy=%b done=%b want busy=0 done=1", busy, done);
    end
    total++;
    if (res_cnt - r0 != 9) begin
      bad++;
      $display("FAIL basic_res_before_done: got %0d want 9", res_cnt - r0);
    end
    total++;
    if (issq.size() != 9) begin
      bad++;
      $display("FAIL basic_issue_count: got %0d want 9", issq.size());
    end
    k = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (k < issq.size()) begin
          total++;
          if (issq[k] !== {10'(r), 10'(c)}) begin
            bad++;
            $display("FAIL basic_coord%0d: got (%0d,%0d) want (%0d,%0d)", k,
                     issq[k][19:10], issq[k][9:0], r, c);
          end
        end
        k++;
      end
    end
    repeat (10) tick();
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL basic_done_once: got %0d pulses want 1", done_cnt - d0);
    end
    bus.win_rdy = 1'b0;
  endtask

  task automatic test_min_frame();
    dp_en = 1'b1;
    bus.win_rdy = 1'b1;
    issq.delete();
    start_frame(3, 3);
    ack_wload("min");
    wait_done(100, "min");
    total++;
    if (issq.size() != 1) begin
      bad++;
      $display("FAIL min_issue_count: got %0d want 1", issq.size());
    end else begin
      total++;
      if (issq[0] !== 20'h0) begin
        bad++;
        $display("FAIL min_coord: got %h want 0", issq[0]);
      end
    end
    bus.win_rdy = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_credit_stall();
    dp_en = 1'b0;
    t_res = '0;
    t_cr = 1'b0;
    bus.win_rdy = 1'b1;
    issq.delete();
    start_frame(6, 6);
    ack_wload("credit");
    repeat (12) tick();
    total++;
    if (issq.size() != 4) begin
      bad++;
      $display("FAIL credit_limit: got %0d issues want 4", issq.size());
    end
    total++;
    if (bus.win_valid !== 1'b0) begin
      bad++;
      $display("FAIL credit_stall_valid: got %b want 0", bus.win_valid);
    end
    t_cr = 1'b1;
    tick();
    t_cr = 1'b0;
    repeat (6) tick();
    total++;
    if (issq.size() != 5) begin
      bad++;
      $display("FAIL credit_one_more: got %0d issues want 5", issq.size());
    end
    bus.win_rdy = 1'b0;
    do_reset();
  endtask

  task automatic test_stall();
    int n = 0;
    int d0, k;
    dp_en = 1'b1;
    bus.win_rdy = 1'b0;
    issq.delete();
    rdy_bad = 0;
    hold_bad = 0;
    hold_en = 1'b1;
    start_frame(6, 4);
    ack_wload("stall");
    d0 = done_cnt;
    while (done_cnt == d0 && n < 400) begin
      bus.win_rdy = ~bus.win_rdy;
      tick();
      n++;
    end
    hold_en = 1'b0;
    bus.win_rdy = 1'b0;
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL stall_done_timeout: got no done want done pulse");
    end
    total++;
    if (issq.size() != 8) begin
      bad++;
      $display("FAIL stall_issue_count: got %0d want 8", issq.size());
    end
    total++;
    if (rdy_bad != 0) begin
      bad++;
      $display("FAIL stall_issue_without_rdy: got %0d want 0", rdy_bad);
    end
    total++;
    if (hold_bad != 0) begin
      bad++;
      $display("FAIL stall_coord_hold: got %0d changes want 0", hold_bad);
    end
    k = 0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (k < issq.size()) begin
          total++;
          if (issq[k] !== {10'(r), 10'(c)}) begin
            bad++;
            $display("FAIL stall_coord%0d: got (%0d,%0d) want (%0d,%0d)", k,
                     issq[k][19:10], issq[k][9:0], r, c);
          end
        end
        k++;
      end
    end
    repeat (10) tick();
  endtask

  task automatic test_cfg_err();
    start_frame(2, 5);
    total++;
    if ({cfg_err, busy, bus.wload_req} !== 3'b100) begin
      bad++;
      $display("FAIL cfgerr_w2: got err/busy/req=%b want 100", {cfg_err, busy, bus.wload_req});
    end
    tick();
    total++;
    if ({cfg_err, busy} !== 2'b00) begin
      bad++;
      $display("FAIL cfgerr_pulse: got err/busy=%b want 00", {cfg_err, busy});
    end
    start_frame(5, 2);
    total++;
    if ({cfg_err, busy} !== 2'b10) begin
      bad++;
      $display("FAIL cfgerr_h2: got err/busy=%b want 10", {cfg_err, busy});
    end
    tick();
  endtask

  task automatic test_simul();
    dp_en = 1'b0;
    t_res = '0;
    t_cr = 1'b0;
    bus.win_rdy = 1'b0;
    total++;
    if (sync_err !== 1'b0) begin
      bad++;
      $display("FAIL simul_sync_clean: got %b want 0", sync_err);
    end
    start_frame(6, 6);
    ack_wload("simul");
    issq.delete();
    bus.win_rdy = 1'b1;
    repeat (3) tick();
    bus.win_rdy = 1'b0;
    tick();
    total++;
    if (issq.size() != 3) begin
      bad++;
      $display("FAIL simul_pre_issues: got %0d want 3", issq.size());
    end
    bus.win_rdy = 1'b1;
    t_cr = 1'b1;
    tick();
    t_cr = 1'b0;
    total++;
    if (bus.win_valid !== 1'b1) begin
      bad++;
      $display("FAIL simul_issue_with_ret: got %b want 1", bus.win_valid);
    end
    tick();
    total++;
    if (bus.win_valid !== 1'b1) begin
      bad++;
      $display("FAIL simul_next_issue: got %b want 1", bus.win_valid);
    end
    tick();
    total++;
    if (bus.win_valid !== 1'b0) begin
      bad++;
      $display("FAIL simul_out_of_credit: got %b want 0", bus.win_valid);
    end
    bus.win_rdy = 1'b0;
    t_res = 8'h0F;
    tick();
    t_res = 8'h00;
    total++;
    if (sync_err !== 1'b1) begin
      bad++;
      $display("FAIL simul_sync_set: got %b want 1", sync_err);
    end
    repeat (3) tick();
    total++;
    if (sync_err !== 1'b1) begin
      bad++;
      $display("FAIL simul_sync_sticky: got %b want 1", sync_err);
    end
    do_reset();
    total++;
    if (sync_err !== 1'b0) begin
      bad++;
      $display("FAIL simul_sync_reset: got %b want 0", sync_err);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int d0, k;
    logic [27:0] v;
    dp_en = 1'b1;
    bus.win_rdy = 1'b1;
    start_frame(6, 6);
    ack_wload("rmid");
    while (!(bus.win_valid && bus.win_row == 10'd1 && bus.win_col == 10'd1) && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (!(bus.win_valid && bus.win_row == 10'd1 && bus.win_col == 10'd1)) begin
      bad++;
      $display("FAIL rmid_reach_11: got (%0d,%0d) want (1,1)", bus.win_row, bus.win_col);
    end
    rstn = 1'b0;
    #1;
    v = {busy, done, cfg_err, sync_err, bus.wload_req, bus.win_valid, bus.win_row, bus.win_col};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL rmid_async_outputs: got %h want 0", v);
    end
    tick();
    v = {busy, done, cfg_err, sync_err, bus.wload_req, bus.win_valid, bus.win_row, bus.win_col};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL rmid_held_outputs: got %h want 0", v);
    end
    rstn = 1'b1;
    issq.delete();
    d0 = done_cnt;
    start_frame(4, 4);
    repeat (4) tick();
    ack_wload("rmid2");
    wait_done(200, "rmid2");
    total++;
    if (issq.size() != 4) begin
      bad++;
      $display("FAIL rmid_issue_count: got %0d want 4", issq.size());
    end
    k = 0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        if (k < issq.size()) begin
          total++;
          if (issq[k] !== {10'(r), 10'(c)}) begin
            bad++;
            $display("FAIL rmid_coord%0d: got (%0d,%0d) want (%0d,%0d)", k,
                     issq[k][19:10], issq[k][9:0], r, c);
          end
        end
        k++;
      end
    end
    repeat (8) tick();
    total++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_done_once: got %0d pulses busy=%b want 1 pulse busy=0",
               done_cnt - d0, busy);
    end
    bus.win_rdy = 1'b0;
  endtask

  initial begin
    bus.win_rdy = 1'b0;
    bus.wload_ack = 1'b0;
    test_reset();
    test_basic();
    test_min_frame();
    test_credit_stall();
    test_stall();
    test_cfg_err();
    test_simul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
- Frame-level sequencer for the 3x3 multi-channel convolution datapath.
- On start it requests a weight-bank load, then raster-scans every valid 3x3 window position of a W x H feature map. It issues one window per cycle to the datapath's valid_in and flow-controls issue with a downstream credit counter.
- It tracks in-flight results and signals done after the last result leaves the datapath.
- Sits between the host/config registers, the window/line-buffer fetcher, the conv datapath and the output buffer.

Parameters:
- COORD_W, 10, width of image dimensions and window coordinates.
- OUT_CH, 8, number of output channels (width of the datapath valid_out vector).
- CREDITS, 4, output-buffer depth; maximum results issued but not yet consumed.
- INFL_W, 6, width of the in-flight counter; must hold CREDITS.

Ports:
- clk, input, 1, clock, rising edge.
- rstn, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that begins a frame.
- cfg_w, input, COORD_W, image width in pixels; latched on accepted start.
- cfg_h, input, COORD_W, image height in pixels; latched on accepted start.
- busy, output, 1, high from accepted start until done.
- done, output, 1, one-cycle pulse at frame end.
- cfg_err, output, 1, one-cycle pulse when start is rejected for bad config.
- wload_req, output, 1, held high until wload_ack; requests a weight_bank refresh.
- wload_ack, input, 1, weight bank is stable.
- win_rdy, input, 1, fetcher has the window at win_row/win_col available.
- win_valid, output, 1, drives the datapath valid_in.
- win_row, output, COORD_W, top-left row of the current window.
- win_col, output, COORD_W, top-left column of the current window.
- res_valid, input, OUT_CH, datapath valid_out.
- credit_ret, input, 1, output buffer consumed one result.
- sync_err, output, 1, sticky; res_valid bits disagreed. Cleared only by reset.

Behaviour:
- Reset values: every output is 0. State is IDLE. The credit counter is CREDITS. The in-flight counter and coordinates are 0.
- States and transitions:
  - IDLE: start with cfg_w>=3 and cfg_h>=3 latches the config, sets busy and goes to WLOAD. Start with either dimension below 3 pulses cfg_err next cycle and stays in IDLE.
  - WLOAD: wload_req=1. On wload_ack, drop wload_req, row=col=0, go to RUN.
  - RUN: issue fires when win_rdy=1 and credits>0. An issue asserts win_valid=1 with the current win_row/win_col, decrements credits and increments in-flight.
  - Coordinates advance on each issue: col increments. At col==cfg_w-3, col wraps to 0 and row increments. The issue at row==cfg_h-3 and col==cfg_w-3 moves to DRAIN.
  - Total issues per frame are exactly (cfg_w-2)*(cfg_h-2).
  - DRAIN: no issue. When in-flight==0 and no res_valid is present this cycle, go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Output timing: win_valid, win_row and win_col are registered. win_valid is low on any cycle without an issue; coordinates hold while stalled.
- Credits:
  - credit_ret increments the counter; an issue decrements it.
  - Simultaneous issue and return leaves the counter unchanged.
  - credit_ret with counter==CREDITS is ignored, saturating.
  - credit_ret is accepted in every state, so late returns after done are absorbed.
- In-flight counter:
  - res_valid[0] decrements it; an issue increments it. Both in one cycle leaves it unchanged.
  - res_valid[0] with in-flight==0 is ignored.
  - res_valid not all-0 and not all-1 sets sync_err; res_valid[0] still governs the count.
- Datapath latency is not a parameter. Completion is purely result-counted.
- start while busy is ignored: no cfg_err, no effect.
- rstn asserted mid-frame returns immediately to IDLE with reset values. In-flight results arriving after reset are ignored because the counter is 0.
- Arithmetic: cfg_w-3 and cfg_h-3 are computed in COORD_W bits after the >=3 check, so no underflow is possible.

Decomposition:
- Shared package conv_pkg (already holding DATA_W/ACC_W/IN_CH/OUT_CH) gains:
  - COORD_W;
  - the state encoding localparams S_IDLE, S_WLOAD, S_RUN, S_DRAIN, S_DONE;
  - MIN_DIM=3.
- One natural sub-module: conv_sched_credit, an up/down saturating counter with a simultaneous inc/dec rule. It is used twice, for credits and for in-flight.

Test Plan:
- cfg 5x5, win_rdy=1, credit_ret returned one cycle after each res_valid, datapath latency 4 -> 9 issues, coords (0,0),(0,1),(0,2),(1,0)..(2,2), done pulses once after the 9th res_valid.
- CREDITS=4, credit_ret held 0 -> exactly 4 issues then win_valid low. A single credit_ret pulse allows exactly one more issue.
- cfg 6x4, win_rdy toggling 1,0,1,0 -> issues only on win_rdy=1 cycles, coordinates held during stalls, 8 total issues.
- start with cfg_w=2 -> cfg_err pulse, busy stays 0, no wload_req.
- Force issue and credit_ret in the same cycle at credits=1 -> counter stays 1, the next cycle still issues. res_valid=8'h0F -> sync_err sticks high.
- rstn low for 1 cycle mid-RUN at coord (1,1) -> all outputs 0 during reset. A subsequent start on 4x4 runs a clean 4-issue frame, unaffected by stale res_valid.
